// File: rtl/simon_enc_arb_if.sv
// rtl/simon_enc_arb_if.sv - requester, response and core-side bundle for simon_enc_arb
interface simon_enc_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 256,
  parameter int KEY_W   = 256
);
  // Requester side
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*KEY_W-1:0]  req_key;
  logic [NUM_REQ-1:0]        req_vld;
  logic [NUM_REQ-1:0]        req_rdy;
  logic [DATA_W-1:0]         rsp_data;
  logic [NUM_REQ-1:0]        rsp_vld;
  logic [NUM_REQ-1:0]        rsp_rdy;
  logic                      key_flush;
  // Core side
  logic [DATA_W-1:0]         core_data_in;
  logic                      core_data_in_vld;
  logic                      core_data_in_rdy;
  logic [KEY_W-1:0]          core_key_in;
  logic                      core_key_in_vld;
  logic                      core_key_in_rdy;
  logic [DATA_W-1:0]         core_data_out;
  logic                      core_data_out_vld;
  logic                      core_data_out_rdy;
  logic                      busy;

  // Arbiter view
  modport master (
    input  req_data, req_key, req_vld, rsp_rdy, key_flush,
    input  core_data_in_rdy, core_key_in_rdy, core_data_out, core_data_out_vld,
    output req_rdy, rsp_data, rsp_vld,
    output core_data_in, core_data_in_vld, core_key_in, core_key_in_vld,
    output core_data_out_rdy, busy
  );

  // Requesters plus core view
  modport slave (
    output req_data, req_key, req_vld, rsp_rdy, key_flush,
    output core_data_in_rdy, core_key_in_rdy, core_data_out, core_data_out_vld,
    input  req_rdy, rsp_data, rsp_vld,
    input  core_data_in, core_data_in_vld, core_key_in, core_key_in_vld,
    input  core_data_out_rdy, busy
  );
endinterface

// File: rtl/simon_enc_arb.sv
// rtl/simon_enc_arb.sv - round-robin sharing of one Simon encrypt core with a key cache
module simon_enc_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 256,
  parameter int KEY_W   = 256
) (
  input logic           clk,
  input logic           rst,
  simon_enc_arb_if.master bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD_KEY  = 3'd1;
  localparam logic [2:0] S_SEND_DATA = 3'd2;
  localparam logic [2:0] S_WAIT_RSP  = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [GW-1:0]     owner_q, owner_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [KEY_W-1:0]  cached_key_q, cached_key_d;
  logic              key_valid_q, key_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic [DATA_W-1:0] req_data_a [NUM_REQ];
  logic [KEY_W-1:0]  req_key_a  [NUM_REQ];
  logic              grant_found;
  logic [GW-1:0]     grant_idx;
  logic [NUM_REQ-1:0] req_rdy_c;
  logic [NUM_REQ-1:0] rsp_vld_c;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_data_a[i] = bus.req_data[i*DATA_W +: DATA_W];
    assign req_key_a[i]  = bus.req_key[i*KEY_W +: KEY_W];
  end

  // Round-robin scan starting one past the last grant, wrapping
  always_comb begin
    logic [GW:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, last_grant_q} + (GW+1)'(k);
      if (idx >= (GW+1)'(NUM_REQ)) idx = idx - (GW+1)'(NUM_REQ);
      if (!grant_found && bus.req_vld[idx[GW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[GW-1:0];
      end
    end
  end

  // Grant is visible in the same cycle it is decided, and only while idle
  always_comb begin
    req_rdy_c = '0;
    if (state_q == S_IDLE && grant_found) req_rdy_c[grant_idx] = 1'b1;
  end

  // Response valid is routed only to the owner of the in-flight transaction
  always_comb begin
    rsp_vld_c = '0;
    if (state_q == S_RESP) rsp_vld_c[owner_q] = 1'b1;
  end

  // Transaction sequencing and key-cache bookkeeping
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    data_d       = data_q;
    key_d        = key_q;
    cached_key_d = cached_key_q;
    key_valid_d  = key_valid_q;
    rsp_data_d   = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          owner_d      = grant_idx;
          last_grant_d = grant_idx;
          data_d       = req_data_a[grant_idx];
          key_d        = req_key_a[grant_idx];
          if (!key_valid_q || (req_key_a[grant_idx] != cached_key_q)) state_d = S_LOAD_KEY;
          else                                                         state_d = S_SEND_DATA;
        end
      end
      S_LOAD_KEY: begin
        if (bus.core_key_in_rdy) begin
          cached_key_d = key_q;
          key_valid_d  = 1'b1;
          state_d      = S_SEND_DATA;
        end
      end
      S_SEND_DATA: begin
        if (bus.core_data_in_rdy) state_d = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        if (bus.core_data_out_vld) begin
          rsp_data_d = bus.core_data_out;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_rdy[owner_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A flush overrides a key load completing in the same cycle
    if (bus.key_flush) key_valid_d = 1'b0;
  end

  // State registers; reset drops any in-flight transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      owner_q      <= '0;
      data_q       <= '0;
      key_q        <= '0;
      cached_key_q <= '0;
      key_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      data_q       <= data_d;
      key_q        <= key_d;
      cached_key_q <= cached_key_d;
      key_valid_q  <= key_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign bus.req_rdy           = req_rdy_c;
  assign bus.rsp_vld           = rsp_vld_c;
  assign bus.rsp_data          = rsp_data_q;
  assign bus.core_key_in       = key_q;
  assign bus.core_key_in_vld   = (state_q == S_LOAD_KEY);
  assign bus.core_data_in      = data_q;
  assign bus.core_data_in_vld  = (state_q == S_SEND_DATA);
  assign bus.core_data_out_rdy = (state_q == S_WAIT_RSP);
  assign bus.busy              = (state_q != S_IDLE);
endmodule

// File: tb/tb_simon_enc_arb.sv
// tb/tb_simon_enc_arb.sv - randomized and directed bench for simon_enc_arb
module tb_simon_enc_arb;
  localparam int NR = 4;
  localparam int DW = 256;
  localparam int KW = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  simon_enc_arb_if #(.NUM_REQ(NR), .DATA_W(DW), .KEY_W(KW)) bus ();
  simon_enc_arb #(.NUM_REQ(NR), .DATA_W(DW), .KEY_W(KW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  int n_keyhs = 0;
  int n_datahs = 0;
  int n_rdy_cyc = 0;
  int grant_log[$];
  int key_rdy_mode = 0;   // 0 random, 1 always ready, 2 never ready
  int hold_out = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rol16(input logic [15:0] v, input int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  // SIMON32/64 reference encryption
  function automatic logic [31:0] simon32(input logic [31:0] pt, input logic [63:0] key);
    logic [15:0] rk [32];
    logic [15:0] x, y, t;
    logic [61:0] z;
    z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    rk[0] = key[15:0];  rk[1] = key[31:16];
    rk[2] = key[47:32]; rk[3] = key[63:48];
    for (int i = 4; i < 32; i++) begin
      t = rol16(rk[i-1], 13) ^ rk[i-3];
      t = t ^ rol16(t, 15);
      rk[i] = ~rk[i-4] ^ t ^ {15'b0, z[61-(i-4)]} ^ 16'd3;
    end
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      t = x;
      x = y ^ (rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2) ^ rk[i];
      y = t;
    end
    return {x, y};
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int rr_pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  // Core model: loads a key, encrypts with it after a random latency
  logic [KW-1:0] c_key;
  logic          c_key_ok;
  logic          c_job;
  logic [31:0]   c_res;
  int            c_lat;
  initial begin
    c_key = '0; c_key_ok = 1'b0; c_job = 1'b0; c_res = '0; c_lat = 0;
    bus.core_key_in_rdy = 1'b0; bus.core_data_in_rdy = 1'b0;
    bus.core_data_out_vld = 1'b0; bus.core_data_out = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        c_key_ok = 1'b0;
        c_job    = 1'b0;
      end else begin
        if (bus.core_key_in_vld && bus.core_key_in_rdy) begin
          c_key = bus.core_key_in; c_key_ok = 1'b1;
        end
        if (bus.core_data_out_vld && bus.core_data_out_rdy) c_job = 1'b0;
        if (bus.core_data_in_vld && bus.core_data_in_rdy) begin
          c_job = 1'b1;
          c_res = c_key_ok ? simon32(bus.core_data_in[31:0], c_key[63:0]) : 32'hdead_beef;
          c_lat = $urandom_range(0, 3);
        end
      end
      @(posedge clk); #1;
      bus.core_key_in_rdy  = (key_rdy_mode == 1) ? 1'b1 :
                             (key_rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
      bus.core_data_in_rdy = ($urandom_range(0, 2) != 0);
      if (c_job && c_lat == 0 && hold_out == 0) begin
        bus.core_data_out_vld = 1'b1;
        bus.core_data_out     = {224'b0, c_res};
      end else begin
        bus.core_data_out_vld = 1'b0;
        bus.core_data_out     = rnd256();
        if (c_job && c_lat > 0) c_lat--;
      end
    end
  end

  // Transaction-level reference and per-cycle compare
  int            m_phase;   // 0 idle, 1 key load, 2 data send, 3 await core, 4 respond
  int            m_last;
  int            m_owner;
  logic          m_valid;
  logic [KW-1:0] m_cached, m_key;
  logic [DW-1:0] m_data, m_exp;
  initial begin
    m_phase = 0; m_last = NR - 1; m_owner = 0; m_valid = 1'b0;
    m_cached = '0; m_key = '0; m_data = '0; m_exp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req_rdy", 256'(bus.req_rdy), 256'd0);
        chk("rst_rsp_vld", 256'(bus.rsp_vld), 256'd0);
        chk("rst_busy", 256'(bus.busy), 256'd0);
        chk("rst_key_vld", 256'(bus.core_key_in_vld), 256'd0);
        chk("rst_data_vld", 256'(bus.core_data_in_vld), 256'd0);
        chk("rst_out_rdy", 256'(bus.core_data_out_rdy), 256'd0);
        chk("rst_rsp_data", bus.rsp_data, 256'd0);
        m_phase = 0; m_last = NR - 1; m_valid = 1'b0;
      end else begin : cyc
        int g;
        logic [NR-1:0] e_rdy, e_rsp;
        g = (m_phase == 0) ? rr_pick(bus.req_vld, m_last) : -1;
        e_rdy = '0;
        if (g >= 0) e_rdy[g] = 1'b1;
        e_rsp = '0;
        if (m_phase == 4) e_rsp[m_owner] = 1'b1;
        chk("req_rdy", 256'(bus.req_rdy), 256'(e_rdy));
        chk("busy", 256'(bus.busy), 256'(m_phase != 0));
        chk("key_in_vld", 256'(bus.core_key_in_vld), 256'(m_phase == 1));
        chk("data_in_vld", 256'(bus.core_data_in_vld), 256'(m_phase == 2));
        chk("data_out_rdy", 256'(bus.core_data_out_rdy), 256'(m_phase == 3));
        chk("rsp_vld", 256'(bus.rsp_vld), 256'(e_rsp));
        if (m_phase == 1) chk("key_in", bus.core_key_in, m_key);
        if (m_phase == 2) chk("data_in", bus.core_data_in, m_data);
        if (m_phase == 4) chk("rsp_data", bus.rsp_data, m_exp);
        if (bus.core_key_in_vld && bus.core_key_in_rdy) n_keyhs++;
        if (bus.core_data_in_vld && bus.core_data_in_rdy) n_datahs++;
        if (bus.req_rdy != '0) begin
          n_rdy_cyc++;
          for (int i = 0; i < NR; i++) if (bus.req_rdy[i]) grant_log.push_back(i);
        end
        case (m_phase)
          0: if (g >= 0) begin
               m_owner = g;
               m_last  = g;
               m_data  = bus.req_data[g*DW +: DW];
               m_key   = bus.req_key[g*KW +: KW];
               m_phase = (!m_valid || m_key != m_cached) ? 1 : 2;
             end
          1: if (bus.core_key_in_rdy) begin
               m_cached = m_key; m_valid = 1'b1; m_phase = 2;
             end
          2: if (bus.core_data_in_rdy) m_phase = 3;
          3: if (bus.core_data_out_vld) begin
               m_exp   = {224'b0, simon32(m_data[31:0], m_key[63:0])};
               m_phase = 4;
             end
          4: if (bus.rsp_rdy[m_owner]) m_phase = 0;
          default: m_phase = 0;
        endcase
        if (bus.key_flush) m_valid = 1'b0;
      end
    end
  end

  task automatic wait_grant(input int r, input string name);
    int c = 0;
    @(negedge clk);
    while (!bus.req_rdy[r] && c < 500) begin @(negedge clk); c++; end
    chk(name, 256'(bus.req_rdy[r]), 256'd1);
    @(posedge clk); #1;
    bus.req_vld[r] = 1'b0;
  endtask

  task automatic send(input int r, input logic [DW-1:0] d, input logic [KW-1:0] k, input string name);
    @(posedge clk); #1;
    bus.req_data[r*DW +: DW] = d;
    bus.req_key[r*KW +: KW]  = k;
    bus.req_vld[r] = 1'b1;
    wait_grant(r, name);
  endtask

  task automatic wait_rsp(input int r, input string name, output logic [DW-1:0] got);
    int c = 0;
    @(negedge clk);
    while (!bus.rsp_vld[r] && c < 500) begin @(negedge clk); c++; end
    chk(name, 256'(bus.rsp_vld[r]), 256'd1);
    got = bus.rsp_data;
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && c < 500) begin @(negedge clk); c++; end
    chk(name, 256'(bus.busy), 256'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [KW-1:0] kpool [3];
  logic [DW-1:0] got, d;
  logic [NR-1:0] acc;
  int kh0, dh0, rc0, c, re0;

  initial begin
    kpool[0] = {192'b0, 64'h1918_1110_0908_0100};
    kpool[1] = {192'b0, 64'h0123_4567_89ab_cdef};
    kpool[2] = kpool[0] | (256'b1 << 200);
    bus.req_data = '0; bus.req_key = '0; bus.req_vld = '0;
    bus.rsp_rdy = '1; bus.key_flush = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("simon_kat", 256'(simon32(32'h6565_6877, 64'h1918_1110_0908_0100)), 256'hc69b_e9bb);
    chk("reset_core_data_in", bus.core_data_in, 256'd0);
    chk("reset_core_key_in", bus.core_key_in, 256'd0);

    // 1: first request loads the key once and returns the known-answer ciphertext
    kh0 = n_keyhs; dh0 = n_datahs;
    send(0, 256'h6565_6877, kpool[0], "t1_grant");
    wait_rsp(0, "t1_rsp_vld", got);
    chk("t1_rsp", got, 256'hc69b_e9bb);
    wait_idle("t1_idle");
    chk("t1_keyhs", 256'(n_keyhs - kh0), 256'd1);
    chk("t1_datahs", 256'(n_datahs - dh0), 256'd1);

    // 2: same key from requester 2 needs no reload
    kh0 = n_keyhs;
    d = rnd256();
    send(2, d, kpool[0], "t2_grant");
    wait_rsp(2, "t2_rsp_vld", got);
    chk("t2_rsp_owner", 256'(bus.rsp_vld), 256'b0100);
    chk("t2_rsp", got, {224'b0, simon32(d[31:0], kpool[0][63:0])});
    wait_idle("t2_idle");
    chk("t2_keyhs", 256'(n_keyhs - kh0), 256'd0);

    // 3: all four requesting with one key, from a fresh reset
    do_reset();
    grant_log.delete();
    kh0 = n_keyhs; rc0 = n_rdy_cyc; re0 = 0;
    for (int i = 0; i < NR; i++) begin
      bus.req_data[i*DW +: DW] = rnd256();
      bus.req_key[i*KW +: KW]  = kpool[0];
    end
    bus.req_vld = '1;
    c = 0;
    while ((bus.req_vld != '0) && c < 600) begin
      @(negedge clk); acc = bus.req_rdy;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          if (i == 0 && re0 == 0) begin
            bus.req_data[0 +: DW] = rnd256();
            re0 = 1;
          end else begin
            bus.req_vld[i] = 1'b0;
          end
        end
      end
      c++;
    end
    wait_idle("t3_idle");
    chk("t3_ngrants", 256'(grant_log.size()), 256'd5);
    if (grant_log.size() >= 5) begin
      chk("t3_g0", 256'(grant_log[0]), 256'd0);
      chk("t3_g1", 256'(grant_log[1]), 256'd1);
      chk("t3_g2", 256'(grant_log[2]), 256'd2);
      chk("t3_g3", 256'(grant_log[3]), 256'd3);
      chk("t3_g4", 256'(grant_log[4]), 256'd0);
    end
    chk("t3_rdy_cycles", 256'(n_rdy_cyc - rc0), 256'd5);
    chk("t3_keyhs", 256'(n_keyhs - kh0), 256'd1);

    // 4: owner stalls the response for 10 cycles
    @(posedge clk); #1;
    bus.rsp_rdy = 4'b1101;
    d = rnd256();
    send(1, d, kpool[0], "t4_grant");
    wait_rsp(1, "t4_rsp_vld", got);
    chk("t4_rsp", got, {224'b0, simon32(d[31:0], kpool[0][63:0])});
    @(posedge clk); #1;
    bus.req_data[3*DW +: DW] = rnd256();
    bus.req_key[3*KW +: KW]  = kpool[0];
    bus.req_vld[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_vld", 256'(bus.rsp_vld), 256'b0010);
      chk("t4_hold_data", bus.rsp_data, got);
      chk("t4_hold_req_rdy", 256'(bus.req_rdy), 256'd0);
      chk("t4_hold_out_rdy", 256'(bus.core_data_out_rdy), 256'd0);
    end
    @(posedge clk); #1;
    bus.rsp_rdy = '1;
    wait_grant(3, "t4_grant3");
    wait_idle("t4_idle");

    // 5: flush between same-key requests, and flush during the key handshake
    kh0 = n_keyhs;
    send(0, rnd256(), kpool[0], "t5_grant_a");
    wait_idle("t5_idle_a");
    chk("t5_hit", 256'(n_keyhs - kh0), 256'd0);
    @(posedge clk); #1; bus.key_flush = 1'b1;
    @(posedge clk); #1; bus.key_flush = 1'b0;
    kh0 = n_keyhs;
    send(0, rnd256(), kpool[0], "t5_grant_b");
    wait_idle("t5_idle_b");
    chk("t5_reload_after_flush", 256'(n_keyhs - kh0), 256'd1);
    key_rdy_mode = 2;
    send(1, rnd256(), kpool[1], "t5_grant_c");
    c = 0;
    @(negedge clk);
    while (!bus.core_key_in_vld && c < 100) begin @(negedge clk); c++; end
    chk("t5_load_seen", 256'(bus.core_key_in_vld), 256'd1);
    key_rdy_mode = 1;
    @(posedge clk); #1; bus.key_flush = 1'b1;
    @(posedge clk); #1; bus.key_flush = 1'b0; key_rdy_mode = 0;
    wait_idle("t5_idle_c");
    kh0 = n_keyhs;
    send(2, rnd256(), kpool[1], "t5_grant_d");
    wait_idle("t5_idle_d");
    chk("t5_reload_after_load_flush", 256'(n_keyhs - kh0), 256'd1);

    // 6: reset while waiting on the core
    hold_out = 1;
    send(1, rnd256(), kpool[1], "t6_grant");
    c = 0;
    @(negedge clk);
    while (!bus.core_data_out_rdy && c < 100) begin @(negedge clk); c++; end
    chk("t6_wait_seen", 256'(bus.core_data_out_rdy), 256'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_busy", 256'(bus.busy), 256'd0);
    chk("t6_out_rdy", 256'(bus.core_data_out_rdy), 256'd0);
    chk("t6_rsp_vld", 256'(bus.rsp_vld), 256'd0);
    chk("t6_req_rdy", 256'(bus.req_rdy), 256'd0);
    chk("t6_core_data_in", bus.core_data_in, 256'd0);
    chk("t6_core_key_in", bus.core_key_in, 256'd0);
    @(posedge clk); #1; hold_out = 0;
    @(posedge clk); #1; rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    kh0 = n_keyhs;
    bus.req_data[0 +: DW]    = rnd256();
    bus.req_key[0 +: KW]     = kpool[1];
    bus.req_data[1*DW +: DW] = rnd256();
    bus.req_key[1*KW +: KW]  = kpool[1];
    bus.req_vld[1:0] = 2'b11;
    c = 0;
    @(negedge clk);
    while (bus.req_rdy == '0 && c < 100) begin @(negedge clk); c++; end
    chk("t6_first_grant", 256'(bus.req_rdy), 256'b0001);
    @(posedge clk); #1; bus.req_vld[0] = 1'b0;
    wait_grant(1, "t6_second_grant");
    wait_idle("t6_idle");
    chk("t6_keyhs", 256'(n_keyhs - kh0), 256'd1);

    // Random traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk); acc = bus.req_rdy;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) bus.req_vld[i] = 1'b0;
        else if (bus.req_vld[i] && $urandom_range(0, 63) == 0) bus.req_vld[i] = 1'b0;
        if (!bus.req_vld[i] && $urandom_range(0, 3) == 0) begin
          bus.req_data[i*DW +: DW] = rnd256();
          bus.req_key[i*KW +: KW]  = kpool[$urandom_range(0, 2)];
          bus.req_vld[i] = 1'b1;
        end
      end
      bus.rsp_rdy   = NR'($urandom);
      bus.key_flush = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk); #1;
    bus.req_vld = '0; bus.key_flush = 1'b0; bus.rsp_rdy = '1;
    wait_idle("drain_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/simon_enc_arb.md
Name: simon_enc_arb

Overview:
- Shares one Simon encrypt core (256-bit data/key valid-ready interface, any SIMON variant) between NUM_REQ requesters.
- Round-robin arbitration with one transaction in flight at a time.
- Key cache: the key is reloaded into the core only when the granted requester's key differs from the last loaded key.
- Results are returned to the owning requester on a per-requester valid/ready response channel.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 256, data width on requester and core side.
- KEY_W, 256, key width on requester and core side.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_data  in  NUM_REQ*DATA_W  plaintext; requester i occupies slice [i*DATA_W +: DATA_W]
- req_key  in  NUM_REQ*KEY_W  key per requester, same slicing
- req_vld  in  NUM_REQ  request valid per requester
- req_rdy  out  NUM_REQ  request accepted (one-hot, single-cycle)
- rsp_data  out  DATA_W  ciphertext (shared by all requesters)
- rsp_vld  out  NUM_REQ  response valid, one-hot to owner
- rsp_rdy  in  NUM_REQ  response ready per requester
- key_flush  in  1  pulse: invalidate key cache
- core_data_in  out  DATA_W;  core_data_in_vld  out  1;  core_data_in_rdy  in  1
- core_key_in  out  KEY_W;  core_key_in_vld  out  1;  core_key_in_rdy  in  1
- core_data_out  in  DATA_W;  core_data_out_vld  in  1;  core_data_out_rdy  out  1
- busy  out  1  high in any state other than IDLE

Behaviour:

Reset:
- Async on rst. State=IDLE; key_valid=0; last_grant=NUM_REQ-1, so requester 0 has priority first.
- All vld/rdy outputs 0; rsp_data/core_data_in/core_key_in = 0.
- The core shares this rst.

Arbitration (IDLE only):
- Scan req_vld starting at (last_grant+1) mod NUM_REQ, wrapping; first set bit wins.
- In the same cycle: req_rdy[g]=1 combinationally; latch data, key and owner g; last_grant<=g.
- If no request is pending, stay in IDLE with req_rdy=0.
- req_rdy is never asserted outside IDLE.

Key check (on grant):
- If key_valid=0, or the latched key != cached_key, go to LOAD_KEY; otherwise go to SEND_DATA.

LOAD_KEY:
- core_key_in_vld=1 holding the latched key.
- On core_key_in_rdy: cached_key<=key, key_valid<=1, go to SEND_DATA.

SEND_DATA:
- core_data_in_vld=1 holding the latched data.
- On core_data_in_rdy: go to WAIT_RSP.

WAIT_RSP:
- core_data_out_rdy=1.
- On core_data_out_vld: latch core_data_out into rsp_data, go to RESP.
- core_data_out_rdy is 0 in every other state.

RESP:
- rsp_vld[owner]=1; rsp_data is stable.
- On rsp_rdy[owner]: go to IDLE.
- rsp_rdy of non-owners is ignored.

Latency:
- With an always-ready core: accept at cycle 0, key handshake at cycle 1 (if needed), data handshake at cycle 1 or 2.
- Response appears 1 cycle after core_data_out_vld.
- Minimum request-to-request spacing = 4 cycles + core latency (+1 if a key load is needed).

key_flush:
- Clears key_valid at the next edge in any state; the cached key value is retained but unused.
- If asserted in the same cycle as the LOAD_KEY handshake, flush wins: key_valid ends at 0.
- An in-flight transaction completes normally.

Handshake stability:
- Every vld stays high with stable payload until its rdy.
- A requester dropping req_vld is harmless because grant and accept happen in the same cycle.

Reset mid-operation:
- Any state returns to IDLE asynchronously.
- The pending transaction is dropped with no response; key_valid=0.

Test Plan:
1. Requester 0 sends data=0x6565_6877, key=0x1918_1110_0908_0100 (SIMON32S64) -> exactly one core key handshake, then one data handshake; rsp_vld[0] returns 0xc69b_e9bb; busy returns low.
2. Repeat the same key from requester 2 with new data -> no core_key_in_vld pulse; result delivered only on rsp_vld[2].
3. req_vld=4'b1111 held, all keys equal -> grant order 0,1,2,3,0; each req_rdy is a single cycle; no key reloads after the first.
4. Hold rsp_rdy[1]=0 for 10 cycles during RESP -> rsp_vld[1] and rsp_data held stable; req_rdy stays 0; core_data_out_rdy=0.
5. Pulse key_flush between two same-key requests -> the second request triggers a key reload. Also assert flush during the LOAD_KEY handshake -> the next same-key request still reloads.
6. Assert rst during WAIT_RSP -> all outputs 0 immediately, state IDLE, no response issued. The next request reloads its key and requester 0 has priority.
